// File: rtl/card_regfile_if.sv
// card_regfile_if -- bus bundle for the card register file.
// Groups the clear/busy handshake, the masked write port, the two read ports
// and the active-entry counter. clk and rst stay plain module ports.
interface card_regfile_if #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 4
);
    logic              clear;
    logic              busy;
    logic              w_enable;
    logic [ADDR_W-1:0] w_address;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] w_mask;
    logic [ADDR_W-1:0] ra_address;
    logic [DATA_W-1:0] ra_data;
    logic [ADDR_W-1:0] rb_address;
    logic [DATA_W-1:0] rb_data;
    logic [ADDR_W:0]   active_cnt;

    // Requester side: issues clears, writes and read addresses.
    modport master (
        output clear, w_enable, w_address, w_data, w_mask, ra_address, rb_address,
        input  busy, ra_data, rb_data, active_cnt
    );

    // Register file side.
    modport slave (
        input  clear, w_enable, w_address, w_data, w_mask, ra_address, rb_address,
        output busy, ra_data, rb_data, active_cnt
    );
endinterface

// File: rtl/card_regfile.sv
// card_regfile -- card state register file.
// Entry layout: bit0 = active, bit1 = discovered, upper bits = colour.
// Two combinational read ports, one masked write port, a clear sweep that
// zeroes one entry per cycle (also started by rst), and a running count of
// entries whose active bit is set.
// Optional macro CARD_RF_BYPASS_EN: forwards an accepted write word to a read
// port addressing the same entry in the write cycle. Without it, reads show
// the pre-write contents until after the write edge.
module card_regfile #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic           clk,
    input  logic           rst,
    card_regfile_if.slave  bus
);

    localparam int                SPAN     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t            state_q;
    logic              busy_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   cnt_q;

    // Full address-space view of the file; addresses at or beyond DEPTH read 0.
    logic [DATA_W-1:0] rd_tbl [SPAN];

    logic              w_in_range;
    logic              wr_acc;
    logic              sweep_zero;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] merged_word;

    assign w_in_range  = ({1'b0, bus.w_address} < DEPTH_L);
    // A write lands only in IDLE, with no clear or rst competing on that edge.
    assign wr_acc      = bus.w_enable & ~busy_q & ~bus.clear & ~rst & w_in_range;
    // rst wins over the sweep too: a restarted sweep leaves the entry at ptr untouched.
    assign sweep_zero  = busy_q & ~rst;
    assign old_word    = rd_tbl[bus.w_address];
    assign merged_word = (old_word & ~bus.w_mask) | (bus.w_data & bus.w_mask);

    genvar gi;
    generate
        for (gi = 0; gi < SPAN; gi++) begin : g_entry
            if (gi < DEPTH) begin : g_real
                logic [DATA_W-1:0] entry_q;
                logic [DATA_W-1:0] entry_d;

                // Next value: sweep zeroing, else masked write, else hold.
                always_comb begin
                    entry_d = entry_q;
                    if (sweep_zero && (ptr_q == ADDR_W'(gi))) begin
                        entry_d = '0;
                    end else if (wr_acc && (bus.w_address == ADDR_W'(gi))) begin
                        entry_d = merged_word;
                    end
                end

                // Entry storage; contents are defined by the first sweep, not by rst.
                always_ff @(posedge clk) begin
                    entry_q <= entry_d;
                end

                assign rd_tbl[gi] = entry_q;
            end else begin : g_pad
                assign rd_tbl[gi] = '0;
            end
        end
    endgenerate

    // Control FSM: rst/clear start a sweep; IDLE tracks the active-bit count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SWEEP;
            busy_q  <= 1'b1;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.clear) begin
                        state_q <= SWEEP;
                        busy_q  <= 1'b1;
                        ptr_q   <= '0;
                        cnt_q   <= '0;
                    end else if (wr_acc) begin
                        if (!old_word[0] && merged_word[0]) begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end else if (old_word[0] && !merged_word[0]) begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                end
                SWEEP: begin
                    if (ptr_q == LAST_PTR) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ptr_q   <= '0;
                    end else begin
                        ptr_q <= ptr_q + PTR_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.active_cnt = cnt_q;

`ifdef CARD_RF_BYPASS_EN
    assign bus.ra_data = (wr_acc && (bus.ra_address == bus.w_address)) ? merged_word
                                                                         : rd_tbl[bus.ra_address];
    assign bus.rb_data = (wr_acc && (bus.rb_address == bus.w_address)) ? merged_word
                                                                         : rd_tbl[bus.rb_address];
`else
    assign bus.ra_data = rd_tbl[bus.ra_address];
    assign bus.rb_data = rd_tbl[bus.rb_address];
`endif

endmodule

// File: tb/tb_card_regfile.sv
// tb_card_regfile -- scoreboard bench for card_regfile.
// Two instances (DEPTH 16 and DEPTH 12) see identical stimulus. A reference
// model of the file contents predicts each cycle's outputs; the driver queues
// the prediction and a negedge monitor pops and compares it.
module tb_card_regfile;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    card_regfile_if #(.DATA_W(14), .ADDR_W(4)) bus16 ();
    card_regfile_if #(.DATA_W(14), .ADDR_W(4)) bus12 ();

    assign bus12.clear      = bus16.clear;
    assign bus12.w_enable   = bus16.w_enable;
    assign bus12.w_address  = bus16.w_address;
    assign bus12.w_data     = bus16.w_data;
    assign bus12.w_mask     = bus16.w_mask;
    assign bus12.ra_address = bus16.ra_address;
    assign bus12.rb_address = bus16.rb_address;

    card_regfile #(.DATA_W(14), .ADDR_W(4), .DEPTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    card_regfile #(.DATA_W(14), .ADDR_W(4), .DEPTH(12)) dut12 (.clk(clk), .rst(rst), .bus(bus12));

    // Reference model: contents, which entries hold a defined value, sweep progress.
    logic [13:0] mem_m   [2][16];
    bit          known_m [2][16];
    int          left_m  [2];
    int          pos_m   [2];
    int          cycle_no = 0;

    typedef struct {
        int          inst;
        int          cyc;
        logic        busy;
        logic [4:0]  cnt;
        logic [13:0] ra;
        logic [13:0] rb;
        bit          ra_k;
        bit          rb_k;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int depth_of(input int k);
        return (k == 0) ? 16 : 12;
    endfunction

    // Active entries = entries whose bit0 is set; reads as 0 while sweeping.
    function automatic logic [4:0] cnt_exp(input int k);
        int c = 0;
        if (left_m[k] > 0) return 5'd0;
        for (int i = 0; i < depth_of(k); i++) c += int'(mem_m[k][i][0]);
        return 5'(c);
    endfunction

    function automatic void rd_exp(input int k, input logic [3:0] a, input bit byp,
                                   input logic [13:0] bw, output logic [13:0] v, output bit kn);
        if (byp) begin
            v  = bw;
            kn = known_m[k][a];
        end else if (int'(a) >= depth_of(k)) begin
            v  = 14'h0;
            kn = 1'b1;
        end else begin
            v  = mem_m[k][a];
            kn = known_m[k][a];
        end
    endfunction

    function automatic void step(input int k, input bit r, input bit c, input bit we,
                                 input logic [3:0] wa, input logic [13:0] wd, input logic [13:0] wm);
        if (r) begin
            left_m[k] = depth_of(k);
            pos_m[k]  = 0;
        end else if (left_m[k] > 0) begin
            mem_m[k][pos_m[k]]   = 14'h0;
            known_m[k][pos_m[k]] = 1'b1;
            pos_m[k]++;
            left_m[k]--;
        end else if (c) begin
            left_m[k] = depth_of(k);
            pos_m[k]  = 0;
        end else if (we && int'(wa) < depth_of(k)) begin
            mem_m[k][wa] = (mem_m[k][wa] & ~wm) | (wd & wm);
        end
    endfunction

    // One clock of stimulus: drive, queue predictions, advance the model.
    task automatic cyc(input bit r, input bit c, input bit we, input logic [3:0] wa,
                       input logic [13:0] wd, input logic [13:0] wm,
                       input logic [3:0] raa, input logic [3:0] rba);
        exp_t        e;
        bit          acc;
        bit          byp_a;
        bit          byp_b;
        logic [13:0] mw;
        rst                 = r;
        bus16.clear         = c;
        bus16.w_enable      = we;
        bus16.w_address     = wa;
        bus16.w_data        = wd;
        bus16.w_mask        = wm;
        bus16.ra_address    = raa;
        bus16.rb_address    = rba;
        for (int k = 0; k < 2; k++) begin
            acc   = !r && !c && we && (left_m[k] == 0) && (int'(wa) < depth_of(k));
            mw    = acc ? ((mem_m[k][wa] & ~wm) | (wd & wm)) : 14'h0;
            byp_a = 1'b0;
            byp_b = 1'b0;
`ifdef CARD_RF_BYPASS_EN
            byp_a = acc && (raa == wa);
            byp_b = acc && (rba == wa);
`endif
            e.inst = k;
            e.cyc  = cycle_no;
            e.busy = (left_m[k] > 0);
            e.cnt  = cnt_exp(k);
            rd_exp(k, raa, byp_a, mw, e.ra, e.ra_k);
            rd_exp(k, rba, byp_b, mw, e.rb, e.rb_k);
            sb_q.push_back(e);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) step(k, r, c, we, wa, wd, wm);
        cycle_no++;
        #1;
    endtask

    task automatic idle_rd(input logic [3:0] raa, input logic [3:0] rba);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 14'h0, 14'h0, raa, rba);
    endtask

    task automatic check(input string name, input int k, input int cy,
                         input logic [13:0] act, input logic [13:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc%0d got %h required %h", name, k, cy, act, req);
        end
    endtask

    // Monitor: compare every queued prediction against the live outputs.
    always @(negedge clk) begin
        exp_t        m;
        logic        a_busy;
        logic [4:0]  a_cnt;
        logic [13:0] a_ra;
        logic [13:0] a_rb;
        while (sb_q.size() > 0) begin
            m      = sb_q.pop_front();
            a_busy = (m.inst == 0) ? bus16.busy       : bus12.busy;
            a_cnt  = (m.inst == 0) ? bus16.active_cnt : bus12.active_cnt;
            a_ra   = (m.inst == 0) ? bus16.ra_data    : bus12.ra_data;
            a_rb   = (m.inst == 0) ? bus16.rb_data    : bus12.rb_data;
            check("busy", m.inst, m.cyc, 14'(a_busy), 14'(m.busy));
            check("active_cnt", m.inst, m.cyc, 14'(a_cnt), 14'(m.cnt));
            if (m.ra_k) check("ra_data", m.inst, m.cyc, a_ra, m.ra);
            if (m.rb_k) check("rb_data", m.inst, m.cyc, a_rb, m.rb);
            $display("cyc %0d inst %0d busy %0b cnt %0d ra %h rb %h", m.cyc, m.inst,
                     a_busy, a_cnt, a_ra, a_rb);
        end
    end

    initial begin
        bit          r;
        bit          c;
        bit          we;
        logic [3:0]  wa;
        logic [3:0]  raa;
        logic [3:0]  rba;
        logic [13:0] wd;
        logic [13:0] wm;

        for (int k = 0; k < 2; k++) begin
            left_m[k] = 0;
            pos_m[k]  = 0;
            for (int i = 0; i < 16; i++) begin
                mem_m[k][i]   = 14'h0;
                known_m[k][i] = 1'b0;
            end
        end
        // Power-up reset: outputs undefined in this cycle, so nothing is queued.
        rst              = 1'b1;
        bus16.clear      = 1'b0;
        bus16.w_enable   = 1'b0;
        bus16.w_address  = 4'd0;
        bus16.w_data     = 14'h0;
        bus16.w_mask     = 14'h0;
        bus16.ra_address = 4'd0;
        bus16.rb_address = 4'd0;
        @(posedge clk);
        for (int k = 0; k < 2; k++) step(k, 1'b1, 1'b0, 1'b0, 4'd0, 14'h0, 14'h0);
        #1;

        // Sweep after reset, then every address reads 0.
        for (int i = 0; i < 16; i++) idle_rd(4'(i), 4'(15 - i));
        for (int i = 0; i < 16; i++) idle_rd(4'(i), 4'(i ^ 5));

        // Full write then a mask that only clears the active bit.
        cyc(1'b0, 1'b0, 1'b1, 4'd3, 14'h1235, 14'h3FFF, 4'd3, 4'd3);
        idle_rd(4'd3, 4'd0);
        cyc(1'b0, 1'b0, 1'b1, 4'd3, 14'h0000, 14'h0001, 4'd3, 4'd0);
        idle_rd(4'd3, 4'd3);

        // Clear races a write: clear wins.
        cyc(1'b0, 1'b0, 1'b1, 4'd5, 14'h0003, 14'h3FFF, 4'd5, 4'd6);
        cyc(1'b0, 1'b1, 1'b1, 4'd6, 14'h3FFF, 14'h3FFF, 4'd5, 4'd6);
        for (int i = 0; i < 18; i++) idle_rd(4'd5, 4'd6);

        // rst mid-sweep restarts; writes during busy are ignored.
        cyc(1'b0, 1'b0, 1'b1, 4'd10, 14'h2F01, 14'h3FFF, 4'd10, 4'd11);
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 14'h0, 14'h0, 4'd10, 4'd0);
        for (int i = 0; i < 7; i++) idle_rd(4'd10, 4'(i));
        cyc(1'b1, 1'b0, 1'b1, 4'd10, 14'h3FFF, 14'h3FFF, 4'd10, 4'd9);
        for (int i = 0; i < 17; i++)
            cyc(1'b0, 1'(i & 1), 1'b1, 4'(i), 14'($urandom), 14'h3FFF, 4'd10, 4'(i));
        for (int i = 0; i < 16; i++) idle_rd(4'(i), 4'(15 - i));

        // Out-of-range write/read on the 12-entry instance.
        cyc(1'b0, 1'b0, 1'b1, 4'd13, 14'h3FFF, 14'h3FFF, 4'd13, 4'd14);
        idle_rd(4'd13, 4'd14);
        cyc(1'b0, 1'b0, 1'b1, 4'd13, 14'h0, 14'h0001, 4'd13, 4'd14);
        idle_rd(4'd13, 4'd14);

        // Same-cycle read of the written entry.
        cyc(1'b0, 1'b0, 1'b1, 4'd2, 14'h0ABC, 14'h3FFF, 4'd2, 4'd2);
        idle_rd(4'd2, 4'd3);

        // Randomised traffic.
        for (int n = 0; n < 500; n++) begin
            r   = ($urandom_range(0, 99) == 0);
            c   = ($urandom_range(0, 39) == 0);
            we  = 1'($urandom_range(0, 1));
            wa  = 4'($urandom_range(0, 15));
            wd  = 14'($urandom);
            wm  = ($urandom_range(0, 2) == 0) ? 14'h3FFF : 14'($urandom);
            raa = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
            rba = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            cyc(r, c, we, wa, wd, wm, raa, rba);
        end

        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
